// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit core sequencer: opcodes, ALU control
// encodings, FSM state codes and instruction field positions.
package core_pkg;

  // Opcodes (ir[15:12]); anything not listed here executes as a NOP
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  // ALU second-operand source select
  localparam logic [1:0] SRC_IMM = 2'b00;
  localparam logic [1:0] SRC_PC  = 2'b01;
  localparam logic [1:0] SRC_REG = 2'b10;

  // Sequencer states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // Instruction field positions
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int DR_HI    = 11;
  localparam int DR_LO    = 9;
  localparam int SR1_HI   = 8;
  localparam int SR1_LO   = 6;
  localparam int IMM_FLAG = 5;
  localparam int SR2_HI   = 2;
  localparam int SR2_LO   = 0;
  localparam int MASK_HI  = 11;
  localparam int MASK_LO  = 9;
  localparam int OFF_HI   = 5;
  localparam int OFF_LO   = 0;

  // True for the opcodes that write the register file and the condition codes
  function automatic logic writes_reg(input logic [3:0] opcode);
    return (opcode == OP_ADD) || (opcode == OP_AND) ||
           (opcode == OP_NOT) || (opcode == OP_LEA);
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// Fetch/decode/execute controller for the 8-bit core. Owns the PC, the
// instruction register and the NZP condition codes, and drives the ALU and
// register-file control fields.
module core_sequencer
  import core_pkg::*;
#(
  parameter int               PC_W     = 6,
  parameter int               INSN_W   = 16,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic [2:0]        sr1_addr,
  output logic [2:0]        sr2_addr,
  output logic [2:0]        dr_addr,
  output logic              reg_we,
  output logic [1:0]        alu_op,
  output logic [1:0]        source_sel,
  output logic [5:0]        ins_immediate,
  output logic [PC_W-1:0]   pc,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_positive,
  output logic [2:0]        cc_nzp,
  output logic              halted
);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [INSN_W-1:0] ir;
  logic [3:0]        opcode;
  logic              br_taken;

  assign opcode   = ir[OPC_HI:OPC_LO];
  assign br_taken = (ir[MASK_HI:MASK_LO] & cc_nzp) != 3'b000;

  assign imem_req      = (state == ST_FETCH);
  assign imem_addr     = pc;
  assign halted        = (state == ST_HALT);
  assign sr1_addr      = ir[SR1_HI:SR1_LO];
  assign sr2_addr      = ir[SR2_HI:SR2_LO];
  assign dr_addr       = ir[DR_HI:DR_LO];
  assign ins_immediate = ir[OFF_HI:OFF_LO];

  // Next-state selection; HALT is absorbing and run only matters in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (run) state_nxt = ST_FETCH;
      ST_FETCH:  if (imem_ready) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = (opcode == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ALU and write-enable controls are only non-default during EXEC
  always_comb begin
    alu_op     = ALU_ADD;
    source_sel = SRC_IMM;
    reg_we     = 1'b0;
    if (state == ST_EXEC) begin
      case (opcode)
        OP_ADD: begin
          alu_op     = ALU_ADD;
          source_sel = ir[IMM_FLAG] ? SRC_IMM : SRC_REG;
          reg_we     = 1'b1;
        end
        OP_AND: begin
          alu_op     = ALU_AND;
          source_sel = ir[IMM_FLAG] ? SRC_IMM : SRC_REG;
          reg_we     = 1'b1;
        end
        OP_NOT: begin
          alu_op     = ALU_NOT;
          source_sel = ir[IMM_FLAG] ? SRC_IMM : SRC_REG;
          reg_we     = 1'b1;
        end
        OP_LEA: begin
          alu_op     = ALU_ADD;
          source_sel = SRC_PC;
          reg_we     = 1'b1;
        end
        default: begin
          alu_op     = ALU_ADD;
          source_sel = SRC_IMM;
          reg_we     = 1'b0;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Instruction register loads only when a fetch completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                ir <= '0;
    else if (state == ST_FETCH && imem_ready)  ir <= imem_rdata;
  end

  // PC increments on fetch completion and takes the branch offset in EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (state == ST_FETCH && imem_ready) begin
      pc <= pc + PC_W'(1);
    end else if (state == ST_EXEC && opcode == OP_BR && br_taken) begin
      pc <= pc + PC_W'(ir[OFF_HI:OFF_LO]);
    end
  end

  // Condition codes follow the ALU flags for every register-writing instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cc_nzp <= 3'b010;
    else if (state == ST_EXEC && writes_reg(opcode))
      cc_nzp <= {alu_negative, alu_zero, alu_positive};
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed scenarios plus random
// instruction streams, compared against an instruction-level model.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [2:0]  sr1_addr;
  logic [2:0]  sr2_addr;
  logic [2:0]  dr_addr;
  logic        reg_we;
  logic [1:0]  alu_op;
  logic [1:0]  source_sel;
  logic [5:0]  ins_immediate;
  logic [5:0]  pc;
  logic        alu_negative;
  logic        alu_zero;
  logic        alu_positive;
  logic [2:0]  cc_nzp;
  logic        halted;

  int nAsserts = 0;
  int nFails   = 0;

  // Architectural model state: program counter and condition codes
  logic [5:0] mpc;
  logic [2:0] mcc;

  core_sequencer #(.PC_W(6), .INSN_W(16), .RESET_PC(6'd0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .sr1_addr(sr1_addr), .sr2_addr(sr2_addr), .dr_addr(dr_addr),
    .reg_we(reg_we), .alu_op(alu_op), .source_sel(source_sel),
    .ins_immediate(ins_immediate), .pc(pc),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_positive(alu_positive),
    .cc_nzp(cc_nzp), .halted(halted)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      $error("[TB] assertion on %s", tag);
    end
  endtask

  // Instruction-set view of the EXEC controls: which instructions write, and what they ask of the ALU
  task automatic refControls(input logic [15:0] insn, output logic we,
                             output logic [1:0] aop, output logic [1:0] src);
    logic [3:0] op;
    op  = insn[15:12];
    we  = 1'b0;
    aop = 2'b00;
    src = 2'b00;
    if (op == 4'h1 || op == 4'h5 || op == 4'h9) begin
      we  = 1'b1;
      aop = (op == 4'h1) ? 2'b00 : (op == 4'h5) ? 2'b01 : 2'b10;
      src = insn[5] ? 2'b00 : 2'b10;
    end else if (op == 4'hE) begin
      we  = 1'b1;
      src = 2'b01;
    end
  endtask

  // Runs one instruction through fetch (with wait states), decode and execute
  task automatic applyStimulus(input logic [15:0] insn, input int waits, input logic [2:0] flags);
    logic       we;
    logic [1:0] aop;
    logic [1:0] src;
    logic [5:0] npc;
    logic [5:0] off;
    refControls(insn, we, aop, src);
    npc = mpc + 6'd1;
    off = insn[5:0];

    checkOutput("fetch_req", imem_req, 1'b1);
    checkOutput("fetch_addr", imem_addr, mpc);
    for (int w = 0; w < waits; w++) begin
      imem_ready = 1'b0;
      imem_rdata = 16'($urandom);
      step();
      checkOutput("stall_req", imem_req, 1'b1);
      checkOutput("stall_addr", imem_addr, mpc);
    end
    imem_ready = 1'b1;
    imem_rdata = insn;
    step();
    imem_ready = 1'b0;
    imem_rdata = 16'($urandom);

    checkOutput("decode_req", imem_req, 1'b0);
    checkOutput("decode_we", reg_we, 1'b0);
    checkOutput("decode_aluop", alu_op, 2'b00);
    checkOutput("decode_src", source_sel, 2'b00);
    checkOutput("decode_dr", dr_addr, insn[11:9]);
    checkOutput("decode_sr1", sr1_addr, insn[8:6]);
    checkOutput("decode_sr2", sr2_addr, insn[2:0]);
    checkOutput("decode_pc", pc, npc);
    {alu_negative, alu_zero, alu_positive} = flags;
    step();

    checkOutput("exec_we", reg_we, we);
    checkOutput("exec_aluop", alu_op, aop);
    checkOutput("exec_src", source_sel, src);
    checkOutput("exec_imm", ins_immediate, insn[5:0]);
    checkOutput("exec_dr", dr_addr, insn[11:9]);
    checkOutput("exec_pc", pc, npc);
    checkOutput("exec_cc", cc_nzp, mcc);
    step();
    {alu_negative, alu_zero, alu_positive} = 3'b000;

    mpc = npc;
    if (we) mcc = flags;
    if (insn[15:12] == 4'h0 && (insn[11:9] & mcc) != 3'b000) mpc = npc + off;
    checkOutput("post_pc", pc, mpc);
    checkOutput("post_cc", cc_nzp, mcc);
    checkOutput("post_halted", halted, insn[15:12] == 4'hF);
  endtask

  // Directed scenarios followed by a random instruction stream
  initial begin
    logic [3:0]  opTable [15];
    logic [15:0] insn;
    logic [5:0]  off;
    opTable = '{4'h0, 4'h1, 4'h5, 4'h9, 4'hE, 4'h2, 4'h3, 4'h4,
                4'h6, 4'h7, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD};

    rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; imem_rdata = 16'h0;
    {alu_negative, alu_zero, alu_positive} = 3'b000;
    step(); step();
    checkOutput("rst_pc", pc, 6'd0);
    checkOutput("rst_cc", cc_nzp, 3'b010);
    checkOutput("rst_req", imem_req, 1'b0);
    checkOutput("rst_we", reg_we, 1'b0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_aluop", alu_op, 2'b00);
    checkOutput("rst_src", source_sel, 2'b00);

    rst_n = 1'b1;
    step();
    checkOutput("idle_no_run", imem_req, 1'b0);
    run = 1'b1;
    step();
    checkOutput("start_req", imem_req, 1'b1);
    checkOutput("start_addr", imem_addr, 6'd0);

    // Reset in the middle of a fetch must drop imem_req without a clock edge
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_req", imem_req, 1'b0);
    checkOutput("async_rst_pc", pc, 6'd0);
    checkOutput("async_rst_cc", cc_nzp, 3'b010);
    step();
    rst_n = 1'b1;
    step();
    run = 1'b0;
    mpc = 6'd0;
    mcc = 3'b010;

    applyStimulus(16'h1265, 0, 3'b001);
    applyStimulus(16'h1481, 4, 3'b010);
    applyStimulus(16'h2000, 0, 3'b100);
    applyStimulus(16'h3123, 1, 3'b100);
    applyStimulus(16'h4FFF, 0, 3'b001);
    checkOutput("br_setup_pc", pc, 6'd5);
    applyStimulus(16'h043E, 0, 3'b100);
    checkOutput("br_taken_pc", pc, 6'd4);
    applyStimulus(16'h5A7F, 0, 3'b001);
    applyStimulus(16'h043E, 2, 3'b100);
    checkOutput("br_not_taken_pc", pc, 6'd6);
    applyStimulus(16'h9A7F, 0, 3'b100);
    applyStimulus(16'h96BF, 0, 3'b010);
    applyStimulus(16'h0000, 0, 3'b001);

    for (int i = 0; i < 40; i++) begin
      insn = {opTable[$urandom_range(0, 14)], 12'($urandom)};
      applyStimulus(insn, $urandom_range(0, 3), 3'b001 << $urandom_range(0, 2));
    end

    // Jump to the last address and let LEA wrap the PC
    off  = 6'd63 - (mpc + 6'd1);
    insn = {4'h0, 3'b111, 3'b000, off};
    applyStimulus(insn, 0, 3'b010);
    checkOutput("jump_to_63", pc, 6'd63);
    applyStimulus(16'hE000, 1, 3'b100);
    checkOutput("lea_wrap_pc", pc, 6'd0);

    applyStimulus(16'hF000, 0, 3'b001);
    for (int i = 0; i < 6; i++) begin
      run        = 1'($urandom);
      imem_ready = 1'($urandom);
      step();
      checkOutput("halt_hold", halted, 1'b1);
      checkOutput("halt_req", imem_req, 1'b0);
      checkOutput("halt_pc", pc, mpc);
    end
    run = 1'b0;
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("halt_reset_halted", halted, 1'b0);
    checkOutput("halt_reset_pc", pc, 6'd0);
    checkOutput("halt_reset_cc", cc_nzp, 3'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle fetch/decode/execute controller for the 8-bit core. It fetches 16-bit instructions from instruction memory over a req/ready handshake and holds the 6-bit PC. It drives the ALU control fields (alu_op, source_sel, ins_immediate, pc) and the register-file read/write addresses. It keeps the NZP condition codes and resolves BR and HALT.

Parameters:
- PC_W, 6, PC and instruction-address width
- INSN_W, 16, instruction width
- RESET_PC, 6'd0, PC value after reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  start request; sampled only in IDLE
- imem_req  out  1  fetch request
- imem_addr  out  6  fetch address (equals pc while imem_req=1)
- imem_rdata  in  16  fetched instruction; valid when imem_ready=1
- imem_ready  in  1  fetch complete; ignored when imem_req=0
- sr1_addr  out  3  register-file read port 1 address
- sr2_addr  out  3  register-file read port 2 address
- dr_addr  out  3  register-file write address
- reg_we  out  1  register-file write enable
- alu_op  out  2  00 add, 01 and, 10 not
- source_sel  out  2  00 immediate, 10 register, 01 pc
- ins_immediate  out  6  ir[5:0]
- pc  out  6  program counter
- alu_negative  in  1  ALU negative flag
- alu_zero  in  1  ALU zero flag
- alu_positive  in  1  ALU positive flag
- cc_nzp  out  3  condition codes {N,Z,P}
- halted  out  1  high in HALT state

Behaviour:
- Instruction fields: opcode ir[15:12], dr ir[11:9], sr1 ir[8:6], imm flag ir[5], imm5 ir[4:0], sr2 ir[2:0], BR mask ir[11:9], offset ir[5:0].
- Opcodes:
  - ADD 0001, AND 0101, NOT 1001, LEA 1110, BR 0000, HALT 1111.
  - Any other opcode is a NOP.
- Reset values: state=IDLE, pc=RESET_PC, ir=0, cc_nzp=3'b010, imem_req=0, reg_we=0, halted=0, alu_op=00, source_sel=00.
- Async reset at any point, including mid-fetch with imem_req high, returns to these values immediately.
- IDLE: stay until run=1, then go to FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Hold until imem_ready=1. Unlimited stall, with imem_addr stable throughout.
  - On ready: ir<=imem_rdata, pc<=pc+1 (mod 64, 63 wraps to 0), go to DECODE.
- DECODE:
  - sr1_addr, sr2_addr and dr_addr are driven from ir.
  - Gives the register file one cycle to present its read data. Next state is EXEC.
- EXEC (exactly one cycle):
  - ADD/AND: alu_op 00/01; source_sel=00 if ir[5]=1, else 10. reg_we=1, cc_nzp<=ALU flags.
  - NOT: alu_op=10; source_sel=00 if ir[5]=1 (NOTI), else 10. reg_we=1, cc updated.
  - LEA: alu_op=00, source_sel=01; ALU sees the already-incremented pc. reg_we=1, cc updated.
  - BR: if (ir[11:9] & cc_nzp)!=0 then pc<=pc+ir[5:0] (mod 64), else pc unchanged. No reg_we, no cc update. Mask 000 never branches.
  - HALT: go to HALT, no writes.
  - NOP: no writes.
  - All other EXEC cases go to FETCH next cycle.
- reg_we is high only in EXEC, for ADD/AND/NOT/LEA. Outside EXEC, alu_op and source_sel hold 00.
- HALT: halted=1, imem_req=0. Absorbing; run is ignored; only reset exits.
- run is ignored outside IDLE; dropping it mid-program has no effect.
- Latency: 3 cycles per instruction with zero-wait memory; each memory wait state adds 1 cycle.
- If cc_nzp were ever all-zero it would be kept as is, but the reachable value set is one-hot.

Decomposition:
- Shared package core_pkg:
  - opcode localparams.
  - ALU encodings ALU_ADD/ALU_AND/ALU_NOT and SRC_IMM/SRC_REG/SRC_PC.
  - state enum {IDLE, FETCH, DECODE, EXEC, HALT}.
  - instruction field slice constants.
- No sub-module: a single FSM plus the ir, pc and cc registers.

Test Plan:
- Reset and start: assert rst_n low mid-fetch with imem_req=1 -> imem_req drops without a clock edge, pc=0, cc=010. Release, run=1 -> imem_req=1 with imem_addr=0 two cycles later.
- ADD immediate: 0x1265 (ADD R1,R1,#5), zero-wait -> EXEC has alu_op=00, source_sel=00, ins_immediate=6'h25, dr=1, reg_we=1; ALU flags 001 -> cc=001; pc 0->1; 3 cycles total.
- Memory stall: hold imem_ready=0 for 4 cycles -> imem_addr stays constant, no state change; instruction completes in 7 cycles.
- Branch: cc=010, BR z with offset 6'h3E at pc=5 -> pc=6+0x3E mod 64 = 4. Same instruction with cc=001 -> pc=6.
- LEA and wrap: LEA at pc=63 -> pc wraps to 0, EXEC drives source_sel=01, alu_op=00, pc=0, reg_we=1.
- HALT: opcode F -> halted=1 from the next cycle; run pulses and imem_ready are ignored; only rst_n clears it.
